// File: rtl/tile_fetch_pipe_if.sv
// rtl/tile_fetch_pipe_if.sv - raster-in / tile-map / pattern-address bundle for tile_fetch_pipe
interface tile_fetch_pipe_if #(
    parameter int FIELD_W   = 256,
    parameter int FIELD_H   = 240,
    parameter int TILE_LOG2 = 3,
    parameter int CODE_W    = 8
);
    localparam int MAP_AW = $clog2((FIELD_W >> TILE_LOG2) * (FIELD_H >> TILE_LOG2));

    logic [9:0]                  col;
    logic [8:0]                  row;
    logic                        vga_blank;
    logic                        flip_req;
    logic                        map_rd_en;
    logic [MAP_AW-1:0]           map_addr;
    logic [CODE_W-1:0]           map_data;
    logic [CODE_W+TILE_LOG2-1:0] pat_addr;
    logic [TILE_LOG2-1:0]        pix_col;
    logic                        out_blank;
    logic                        flip_active;

    // master: timing generator plus tile-map RAM side; slave: the fetch pipe
    modport master (
        output col, row, vga_blank, flip_req, map_data,
        input  map_rd_en, map_addr, pat_addr, pix_col, out_blank, flip_active
    );

    modport slave (
        input  col, row, vga_blank, flip_req, map_data,
        output map_rd_en, map_addr, pat_addr, pix_col, out_blank, flip_active
    );
endinterface

// File: rtl/tile_fetch_pipe.sv
// rtl/tile_fetch_pipe.sv - 3-stage VGA raster to tile-map / pattern-ROM address pipeline
module tile_fetch_pipe #(
    parameter int H_OFFSET  = 192,
    parameter int V_OFFSET  = 120,
    parameter int FIELD_W   = 256,
    parameter int FIELD_H   = 240,
    parameter int TILE_LOG2 = 3,
    parameter int CODE_W    = 8
) (
    input  logic             clk,
    input  logic             rst_l,
    tile_fetch_pipe_if.slave bus
);
    localparam int MAP_COLS = FIELD_W >> TILE_LOG2;
    localparam int MAP_ROWS = FIELD_H >> TILE_LOG2;
    localparam int MAP_AW   = $clog2(MAP_COLS * MAP_ROWS);
    localparam int CX_W     = $clog2(FIELD_W);
    localparam int CY_W     = $clog2(FIELD_H);
    localparam int TX_W     = CX_W - TILE_LOG2;
    localparam int TY_W     = CY_W - TILE_LOG2;

    logic                 in_win;
    logic [CX_W-1:0]      cx;
    logic [CY_W-1:0]      cy;
    logic [TX_W-1:0]      tx, tx_f;
    logic [TY_W-1:0]      ty, ty_f;
    logic [TILE_LOG2-1:0] px, py, px_f, py_f;
    logic [MAP_AW-1:0]    addr_nxt;

    logic                 flip_q;
    logic                 rd_en_q;
    logic [MAP_AW-1:0]    addr_q;
    logic [TILE_LOG2-1:0] px1_q, py1_q, px2_q, py2_q;
    logic                 blank1_q, blank2_q;
    logic [CODE_W+TILE_LOG2-1:0] pat_q;
    logic [TILE_LOG2-1:0] pix_q;
    logic                 out_blank_q;

    // Window bounds are compared at full 32-bit width so no offset can wrap.
    assign in_win = !bus.vga_blank
                 && (32'(bus.row) >= V_OFFSET) && (32'(bus.row) < V_OFFSET + FIELD_H)
                 && (32'(bus.col) >= H_OFFSET) && (32'(bus.col) < H_OFFSET + FIELD_W);

    assign cx = CX_W'(bus.col - 10'(H_OFFSET));
    assign cy = CY_W'(bus.row - 9'(V_OFFSET));
    assign tx = cx[CX_W-1:TILE_LOG2];
    assign ty = cy[CY_W-1:TILE_LOG2];
    assign px = cx[TILE_LOG2-1:0];
    assign py = cy[TILE_LOG2-1:0];

    // Cocktail flip mirrors both the tile grid and the pixel within the tile.
    assign tx_f = flip_q ? TX_W'(MAP_COLS - 1) - tx : tx;
    assign ty_f = flip_q ? TY_W'(MAP_ROWS - 1) - ty : ty;
    assign px_f = flip_q ? ~px : px;
    assign py_f = flip_q ? ~py : py;

    assign addr_nxt = MAP_AW'(ty_f) * MAP_AW'(MAP_COLS) + MAP_AW'(tx_f);

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            flip_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            px1_q       <= '0;
            py1_q       <= '0;
            blank1_q    <= 1'b1;
            px2_q       <= '0;
            py2_q       <= '0;
            blank2_q    <= 1'b1;
            pat_q       <= '0;
            pix_q       <= '0;
            out_blank_q <= 1'b1;
        end else begin
            // Flip only changes at frame start so a frame is never half-mirrored.
            if (bus.col == 10'd0 && bus.row == 9'd0) begin
                flip_q <= bus.flip_req;
            end

            rd_en_q  <= in_win;
            addr_q   <= in_win ? addr_nxt : '0;
            px1_q    <= in_win ? px_f : '0;
            py1_q    <= in_win ? py_f : '0;
            blank1_q <= !in_win;

            // Stage 2 waits out the tile-map RAM read latency.
            px2_q    <= px1_q;
            py2_q    <= py1_q;
            blank2_q <= blank1_q;

            pat_q       <= blank2_q ? '0 : {bus.map_data, py2_q};
            pix_q       <= blank2_q ? '0 : px2_q;
            out_blank_q <= blank2_q;
        end
    end

    assign bus.map_rd_en   = rd_en_q;
    assign bus.map_addr    = addr_q;
    assign bus.pat_addr    = pat_q;
    assign bus.pix_col     = pix_q;
    assign bus.out_blank   = out_blank_q;
    assign bus.flip_active = flip_q;
endmodule

// File: tb/tb_tile_fetch_pipe.sv
// tb/tb_tile_fetch_pipe.sv - scoreboard bench for tile_fetch_pipe with randomized and raster stimulus
module tb_tile_fetch_pipe;
    localparam int H_OFF = 192;
    localparam int V_OFF = 120;
    localparam int FW    = 256;
    localparam int FH    = 240;
    localparam int TILE  = 8;
    localparam int MCOLS = FW / TILE;
    localparam int MROWS = FH / TILE;

    typedef struct {
        bit rst;
        bit rd_en;
        int addr;
        int pat;
        int pixc;
        bit blank;
        bit flip_after;
        int lit_addr;
        int lit_pixc;
        int lit_pat;
    } exp_t;

    logic clk;
    logic rst_l;
    logic [7:0] mem [0:1023];
    exp_t exp_q[$];
    bit   model_flip;
    int   checks;
    int   errors;

    tile_fetch_pipe_if bus ();

    tile_fetch_pipe dut (
        .clk  (clk),
        .rst_l(rst_l),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous tile-map RAM: data appears one edge after the read enable.
    always @(posedge clk) begin
        if (bus.map_rd_en) bus.map_data <= mem[bus.map_addr];
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive(input int c, input int r, input bit vb, input bit fr, input bit rs,
                         input int la = -1, input int lx = -1, input int lp = -1);
        exp_t e;
        int cx, cy, tx, ty, px, py;
        bit inwin;
        @(negedge clk);
        bus.col       = 10'(c);
        bus.row       = 9'(r);
        bus.vga_blank = vb;
        bus.flip_req  = fr;
        rst_l         = rs ? 1'b0 : 1'b1;
        e = '{default: 0};
        e.rst = rs;
        e.lit_addr = la;
        e.lit_pixc = lx;
        e.lit_pat  = lp;
        inwin = !vb && r >= V_OFF && r < V_OFF + FH && c >= H_OFF && c < H_OFF + FW;
        if (!rs && inwin) begin
            cx = c - H_OFF;
            cy = r - V_OFF;
            tx = cx / TILE;
            ty = cy / TILE;
            px = cx % TILE;
            py = cy % TILE;
            if (model_flip) begin
                tx = MCOLS - 1 - tx;
                ty = MROWS - 1 - ty;
                px = TILE - 1 - px;
                py = TILE - 1 - py;
            end
            e.rd_en = 1;
            e.addr  = ty * MCOLS + tx;
            e.pat   = int'(mem[e.addr]) * TILE + py;
            e.pixc  = px;
            e.blank = 0;
        end else begin
            e.blank = 1;
        end
        if (rs) model_flip = 0;
        else if (c == 0 && r == 0) model_flip = fr;
        e.flip_after = model_flip;
        exp_q.push_back(e);
    endtask

    // Monitor: one sample per edge; final outputs belong to the sample two edges older.
    initial begin
        exp_t e;
        exp_t h;
        exp_t pipe[$];
        bit poison;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("map_rd_en", int'(bus.map_rd_en), int'(e.rd_en));
                chk("map_addr", int'(bus.map_addr), e.addr);
                chk("flip_active", int'(bus.flip_active), int'(e.flip_after));
                if (e.lit_addr >= 0) chk("directed_map_addr", int'(bus.map_addr), e.lit_addr);
                pipe.push_back(e);
                if (pipe.size() == 3) begin
                    h = pipe[0];
                    poison = pipe[0].rst || pipe[1].rst || pipe[2].rst;
                    if (poison || h.blank) begin
                        chk("pat_addr_blank", int'(bus.pat_addr), 0);
                        chk("pix_col_blank", int'(bus.pix_col), 0);
                        chk("out_blank_blank", int'(bus.out_blank), 1);
                    end else begin
                        chk("pat_addr", int'(bus.pat_addr), h.pat);
                        chk("pix_col", int'(bus.pix_col), h.pixc);
                        chk("out_blank", int'(bus.out_blank), 0);
                        if (h.lit_pixc >= 0) chk("directed_pix_col", int'(bus.pix_col), h.lit_pixc);
                        if (h.lit_pat >= 0) chk("directed_pat_addr", int'(bus.pat_addr), h.lit_pat);
                    end
                    void'(pipe.pop_front());
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        model_flip = 0;
        rst_l = 1'b0;
        bus.col = '0;
        bus.row = '0;
        bus.vga_blank = 1'b0;
        bus.flip_req = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[0]   = 8'h5A;
        mem[959] = 8'h3C;
        mem[926] = 8'hA5;

        for (int i = 0; i < 3; i++) drive(5, 5, 0, 0, 1);

        // Window origin and far corner, then just outside on the right.
        drive(192, 120, 0, 0, 0, 0, 0, 'h2D0);
        drive(447, 359, 0, 0, 0, 959, 7, 'h3C * 8 + 7);
        drive(448, 359, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(10, 10, 0, 0, 0);

        drive(191, 120, 0, 0, 0);
        drive(192, 119, 0, 0, 0);
        drive(447, 120, 0, 0, 0);
        drive(192, 359, 0, 0, 0);
        drive(192, 360, 0, 0, 0);
        drive(300, 200, 1, 0, 0);

        // Flip latched at frame start mirrors tile and pixel.
        drive(0, 0, 0, 1, 0);
        drive(200, 128, 0, 1, 0, 926, 7, 'hA5 * 8 + 7);
        drive(447, 359, 0, 0, 0, 0, 0);

        // Mid-frame flip request is deferred to the next frame start.
        drive(0, 0, 0, 0, 0);
        for (int c = 240; c < 250; c++) drive(c, 200, 0, 1, 0);
        drive(200, 128, 0, 1, 0, 33, 0);
        drive(0, 0, 0, 1, 0);
        drive(200, 128, 0, 1, 0, 926, 7);
        drive(0, 0, 0, 0, 0);

        // One-cycle reset in the middle of an in-window run.
        for (int c = 200; c < 216; c++) drive(c, 150, 0, 0, c == 205);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(49, 0) == 0)
                drive(0, 0, 0, 1'($urandom), 0);
            else
                drive($urandom_range(460, 180), $urandom_range(370, 110),
                      $urandom_range(7, 0) == 0, 1'($urandom), $urandom_range(299, 0) == 0);
        end

        for (int i = 0; i < 3; i++) drive(10, 10, 0, 0, 0);
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i);

        // Raster scan over the window and its border, flip off.
        drive(0, 0, 0, 0, 0);
        for (int r = 118; r < 362; r++)
            for (int c = 189; c < 451; c++)
                drive(c, r, $urandom_range(15, 0) == 0, 0, 0);

        for (int i = 0; i < 4; i++) drive(10, 10, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
